// File: rtl/vta_axi_pkg.sv
// Shared AXI read-channel codes, VTA instruction width and the read-slave FSM state type.
package vta_axi_pkg;
    localparam int VTA_INS_WIDTH = 128;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_16B   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } rd_state_e;
endpackage

// File: rtl/insn_mem_axi_rd_slave_if.sv
// AXI4 read-only channel (AR + R) between the VTA fetch master and an instruction store.
interface insn_mem_axi_rd_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/insn_mem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
module insn_mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/insn_mem_axi_rd_slave.sv
// AXI4 INCR-burst read responder serving 128-bit VTA instructions from a preloadable array.
module insn_mem_axi_rd_slave
    import vta_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = VTA_INS_WIDTH,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    insn_mem_axi_rd_slave_if.slave  s_axi_ins_port,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    busy
);
    localparam int         IDX_W = ADDR_WIDTH - 4;
    localparam logic [3:0] LAT   = 4'(RD_LATENCY);

    rd_state_e state, state_nx;

    logic [IDX_W-1:0]      idx, ld_idx, ar_idx;
    logic [7:0]            cnt, ld_cnt;
    logic                  slverr, ld_slverr, below, ld_below;
    logic [3:0]            lat_cnt;
    logic                  ld;
    logic                  arready, rvalid, rlast;
    logic [1:0]            rresp, beat_resp;
    logic [DATA_WIDTH-1:0] rdata, beat_data, mem_q;
    logic [ADDR_WIDTH-1:0] ar_off;
    logic                  ar_hs, r_hs, ar_err, ar_below, in_range;

    assign ar_hs    = s_axi_ins_port.ARVALID & arready;
    assign r_hs     = rvalid & s_axi_ins_port.RREADY;
    assign ar_off   = s_axi_ins_port.ARADDR - BASE_ADDR;
    assign ar_idx   = IDX_W'(ar_off >> 4);
    assign ar_err   = (s_axi_ins_port.ARSIZE != SIZE_16B) || (s_axi_ins_port.ARBURST != BURST_INCR);
    assign ar_below = s_axi_ins_port.ARADDR < BASE_ADDR;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_IDLE;
        else           state <= state_nx;
    end

    // ld_* is the beat about to be presented; it also becomes the burst context register.
    always_comb begin
        state_nx  = state;
        ld        = 1'b0;
        ld_idx    = idx;
        ld_cnt    = cnt;
        ld_slverr = slverr;
        ld_below  = below;
        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    ld_idx    = ar_idx;
                    ld_cnt    = s_axi_ins_port.ARLEN;
                    ld_slverr = ar_err;
                    ld_below  = ar_below;
                    if (RD_LATENCY == 0) begin
                        state_nx = ST_BURST;
                        ld       = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT) begin
                    state_nx = ST_BURST;
                    ld       = 1'b1;
                end
            end
            ST_BURST: begin
                if (r_hs) begin
                    if (cnt == 8'd0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        ld     = 1'b1;
                        ld_idx = idx + 1'b1;
                        ld_cnt = cnt - 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Range check on the full index so high address bits cannot alias into the array.
    assign in_range = (ld_idx >> DEPTH_LOG2) == '0;

    always_comb begin
        beat_data = '0;
        beat_resp = RESP_OKAY;
        if (ld_slverr)                 beat_resp = RESP_SLVERR;
        else if (ld_below || !in_range) beat_resp = RESP_DECERR;
        else                           beat_data = mem_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            idx     <= '0;
            cnt     <= '0;
            slverr  <= 1'b0;
            below   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            arready <= (state_nx == ST_IDLE);
            idx     <= ld_idx;
            cnt     <= ld_cnt;
            slverr  <= ld_slverr;
            below   <= ld_below;
            lat_cnt <= (state == ST_WAIT) ? lat_cnt + 1'b1 : 4'd0;
            if (ld) begin
                rvalid <= 1'b1;
                rlast  <= (ld_cnt == 8'd0);
                rresp  <= beat_resp;
                rdata  <= beat_data;
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    insn_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (ap_clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ld_idx[DEPTH_LOG2-1:0]),
        .rdata (mem_q)
    );

    assign s_axi_ins_port.ARREADY = arready;
    assign s_axi_ins_port.RVALID  = rvalid;
    assign s_axi_ins_port.RLAST   = rlast;
    assign s_axi_ins_port.RRESP   = rresp;
    assign s_axi_ins_port.RDATA   = rdata;
    assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_insn_mem_axi_rd_slave.sv
// Bench for insn_mem_axi_rd_slave: burst table with scoreboard, latency and reset sequences.
module tb_insn_mem_axi_rd_slave;
    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        bit          stall;
        logic [1:0]  exp_first;
        logic [1:0]  exp_last;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic         busy1, busy3;

    always #5 ap_clk = ~ap_clk;

    insn_mem_axi_rd_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) axi1 ();
    insn_mem_axi_rd_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) axi3 ();

    insn_mem_axi_rd_slave #(.RD_LATENCY(1)) u_dut (
        .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .s_axi_ins_port (axi1),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .busy (busy1)
    );

    insn_mem_axi_rd_slave #(.RD_LATENCY(3)) u_dut3 (
        .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .s_axi_ins_port (axi3),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .busy (busy3)
    );

    int           checks = 0;
    int           errors = 0;
    logic [127:0] mem_model [256];
    beat_t        exp_q [$];
    beat_t        held, mon_e;
    bit           mon_en = 1'b0;
    bit           held_v = 1'b0;
    int           beat_no = 0;
    logic [1:0]   first_resp, last_resp;
    vec_t         vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [7:0] l,
                                input logic [2:0] s, input logic [1:0] b, input bit st,
                                input logic [1:0] ef, input logic [1:0] el);
        vec_t v;
        v.name = n; v.addr = a; v.len = l; v.size = s; v.burst = b;
        v.stall = st; v.exp_first = ef; v.exp_last = el;
        return v;
    endfunction

    function automatic beat_t model_beat(input logic [31:0] addr, input int i, input int len,
                                         input logic [2:0] size, input logic [1:0] burst);
        beat_t  b;
        longint idx;
        idx    = longint'(addr >> 4) + longint'(i);
        b.last = (i == len);
        b.data = '0;
        if (size != 3'd4 || burst != 2'b01) b.resp = 2'b10;
        else if (idx >= 256)                b.resp = 2'b11;
        else begin
            b.resp = 2'b00;
            b.data = mem_model[int'(idx)];
        end
        return b;
    endfunction

    // Scoreboard on the R channel of the RD_LATENCY=1 instance.
    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (held_v) begin
                chk("hold_valid", 128'(axi1.RVALID), 128'(1));
                chk("hold_data", axi1.RDATA, held.data);
                chk("hold_resp", 128'(axi1.RRESP), 128'(held.resp));
                chk("hold_last", 128'(axi1.RLAST), 128'(held.last));
            end
            held_v    = axi1.RVALID && !axi1.RREADY;
            held.data = axi1.RDATA;
            held.resp = axi1.RRESP;
            held.last = axi1.RLAST;
            if (axi1.RVALID && axi1.RREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got beat data %h, expected no beat", axi1.RDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("beat%0d_data", beat_no), axi1.RDATA, mon_e.data);
                    chk($sformatf("beat%0d_resp", beat_no), 128'(axi1.RRESP), 128'(mon_e.resp));
                    chk($sformatf("beat%0d_last", beat_no), 128'(axi1.RLAST), 128'(mon_e.last));
                    if (beat_no == 0) first_resp = axi1.RRESP;
                    last_resp = axi1.RRESP;
                    beat_no++;
                end
            end
        end
    end

    task automatic issue_ar1(input vec_t v, output bit ok);
        int cyc;
        @(posedge ap_clk); #1;
        axi1.ARADDR = v.addr; axi1.ARLEN = v.len; axi1.ARSIZE = v.size;
        axi1.ARBURST = v.burst; axi1.ARVALID = 1'b1;
        cyc = 0;
        while (!axi1.ARREADY && cyc < 20) begin
            @(posedge ap_clk); #1;
            cyc++;
        end
        ok = axi1.ARREADY;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_ar_timeout: got ARREADY 0, expected 1 within 20 cycles", v.name);
        end
        @(posedge ap_clk); #1;
        axi1.ARVALID = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int         cyc;
        int         k;
        bit         ok;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i <= int'(v.len); i++)
            exp_q.push_back(model_beat(v.addr, i, int'(v.len), v.size, v.burst));
        beat_no = 0; held_v = 1'b0; mon_en = 1'b1;
        k = 0;
        axi1.RREADY = v.stall ? pat[0] : 1'b1;
        issue_ar1(v, ok);
        cyc = 0;
        while (ok && exp_q.size() != 0 && cyc < 200) begin
            @(posedge ap_clk); #1;
            cyc++;
            k++;
            if (v.stall) axi1.RREADY = pat[k % 4];
        end
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_r_timeout: got %0d beats outstanding, expected 0", v.name, exp_q.size());
            exp_q.delete();
        end
        if (!v.stall) chk({v.name, "_cycles"}, 128'(cyc), 128'(int'(v.len) + 3));
        chk({v.name, "_nbeats"}, 128'(beat_no), 128'(int'(v.len) + 1));
        chk({v.name, "_first_resp"}, 128'(first_resp), 128'(v.exp_first));
        chk({v.name, "_last_resp"}, 128'(last_resp), 128'(v.exp_last));
        chk({v.name, "_rvalid_after"}, 128'(axi1.RVALID), 128'(0));
        chk({v.name, "_arready_after"}, 128'(axi1.ARREADY), 128'(1));
        chk({v.name, "_busy_after"}, 128'(busy1), 128'(0));
        axi1.RREADY = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;
        axi1.ARVALID = 1'b0; axi1.ARADDR = '0; axi1.ARLEN = '0; axi1.ARSIZE = 3'd4;
        axi1.ARBURST = 2'b01; axi1.RREADY = 1'b0;
        axi3.ARVALID = 1'b0; axi3.ARADDR = '0; axi3.ARLEN = '0; axi3.ARSIZE = 3'd4;
        axi3.ARBURST = 2'b01; axi3.RREADY = 1'b0;

        vecs[0] = mk("incr5",    32'h0000_0000, 8'd4, 3'd4, 2'b01, 1'b0, 2'b00, 2'b00);
        vecs[1] = mk("stall5",   32'h0000_0000, 8'd4, 3'd4, 2'b01, 1'b1, 2'b00, 2'b00);
        vecs[2] = mk("slverr3",  32'h0000_0000, 8'd2, 3'd3, 2'b01, 1'b0, 2'b10, 2'b10);
        vecs[3] = mk("edge4",    32'h0000_0FE0, 8'd3, 3'd4, 2'b01, 1'b0, 2'b00, 2'b11);
        vecs[4] = mk("wrap_err", 32'h0000_0020, 8'd1, 3'd4, 2'b10, 1'b1, 2'b10, 2'b10);
        vecs[5] = mk("single",   32'h0000_0030, 8'd0, 3'd4, 2'b01, 1'b0, 2'b00, 2'b00);
        vecs[6] = mk("oor2",     32'h0000_1000, 8'd1, 3'd4, 2'b01, 1'b0, 2'b11, 2'b11);
        vecs[7] = mk("highaddr", 32'h8000_0000, 8'd0, 3'd4, 2'b01, 1'b0, 2'b11, 2'b11);

        // Reset state and ARREADY rising one cycle after release.
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_arready", 128'(axi1.ARREADY), 128'(0));
        chk("rst_rvalid", 128'(axi1.RVALID), 128'(0));
        chk("rst_rlast", 128'(axi1.RLAST), 128'(0));
        chk("rst_rresp", 128'(axi1.RRESP), 128'(0));
        chk("rst_rdata", axi1.RDATA, 128'(0));
        chk("rst_busy", 128'(busy1), 128'(0));
        ap_rst_n = 1'b1;
        #1;
        chk("rel_arready_0", 128'(axi1.ARREADY), 128'(0));
        @(posedge ap_clk); #1;
        chk("rel_arready_1", 128'(axi1.ARREADY), 128'(1));

        // Preload: LOAD/STORE/ALU/LOAD/GEMM in words 0..4, random elsewhere.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0: wr_data = 128'h0000_0010_0000_0100_0020_0001_0000_0000;
                1: wr_data = 128'h0000_0020_0000_0200_0040_0002_0000_0001;
                2: wr_data = 128'h0000_0000_0008_0010_0000_0040_0000_0004;
                3: wr_data = 128'h0000_0030_0000_0300_0060_0003_0000_0008;
                4: wr_data = 128'h0001_0000_0010_0000_0400_0001_0000_0002;
                default: wr_data = {$urandom, $urandom, $urandom, $urandom};
            endcase
            wr_en = 1'b1;
            wr_addr = 8'(i);
            mem_model[i] = wr_data;
            @(posedge ap_clk); #1;
        end
        wr_en = 1'b0;

        foreach (vecs[i]) run_burst(vecs[i]);

        // RD_LATENCY=3 instance: first RVALID exactly 4 cycles after the handshake edge.
        @(posedge ap_clk); #1;
        axi3.ARADDR = 32'h10; axi3.ARLEN = 8'd0; axi3.ARVALID = 1'b1;
        n = 0;
        while (!axi3.ARREADY && n < 20) begin @(posedge ap_clk); #1; n++; end
        chk("lat3_arready", 128'(axi3.ARREADY), 128'(1));
        @(posedge ap_clk); #1;
        axi3.ARVALID = 1'b0;
        n = 0;
        while (!axi3.RVALID && n < 20) begin @(posedge ap_clk); #1; n++; end
        chk("lat3_cycles", 128'(n), 128'(4));
        chk("lat3_data", axi3.RDATA, mem_model[1]);
        chk("lat3_resp", 128'(axi3.RRESP), 128'(0));
        chk("lat3_last", 128'(axi3.RLAST), 128'(1));
        axi3.RREADY = 1'b1;
        @(posedge ap_clk); #1;
        chk("lat3_rvalid_after", 128'(axi3.RVALID), 128'(0));
        chk("lat3_arready_after", 128'(axi3.ARREADY), 128'(1));
        axi3.RREADY = 1'b0;

        // Reset asserted while beat 3 of a 5-beat burst is presented.
        for (int i = 0; i <= 4; i++) exp_q.push_back(model_beat(32'h0, i, 4, 3'd4, 2'b01));
        beat_no = 0; held_v = 1'b0; mon_en = 1'b1;
        axi1.RREADY = 1'b1;
        issue_ar1(vecs[0], ok);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin @(posedge ap_clk); #1; n++; end
        chk("rstmid_beats_before", 128'(beat_no), 128'(2));
        mon_en = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid", 128'(axi1.RVALID), 128'(0));
        chk("rstmid_rlast", 128'(axi1.RLAST), 128'(0));
        chk("rstmid_arready", 128'(axi1.ARREADY), 128'(0));
        chk("rstmid_rdata", axi1.RDATA, 128'(0));
        chk("rstmid_busy", 128'(busy1), 128'(0));
        exp_q.delete();
        axi1.RREADY = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        run_burst(mk("post_rst", 32'h0, 8'd4, 3'd4, 2'b01, 1'b0, 2'b00, 2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
